cacheline_burst_responder: RTL and testbench
============================================

Name: cacheline_burst_responder

Overview:
- Responds on the cache's physical-memory line interface: accepts one 256-bit line read or write per transaction.
- Converts each transaction into a 4-beat, 64-bit burst on the physical memory bus.
- Sits between the cache's pmem_* ports and main memory / arbiter.
- Raises a one-cycle line_resp when the whole line has been transferred.

Parameters:
- s_offset, 5, byte-offset bits within a line; burst address bits [s_offset-1:0] are forced to zero.
- s_line, 256, line width in bits.
- s_beat, 64, burst beat width in bits; number of beats = s_line/s_beat = 4.

Ports:
- clk  input  1  system clock, all state on the rising edge.
- rst  input  1  synchronous, active-high reset.
- line_read  input  1  line fill request from the cache; held until line_resp.
- line_write  input  1  line writeback request from the cache; held until line_resp.
- line_address  input  32  line address; bits [4:0] are ignored.
- line_wdata  input  256  writeback line; beat k is bits [64k+63:64k].
- line_rdata  output  256  assembled fill line.
- line_resp  output  1  one-cycle transaction-complete pulse.
- burst_address  output  32  registered, line-aligned address: {line_address[31:5], 5'b0}.
- burst_read  output  1  burst read request.
- burst_write  output  1  burst write request.
- burst_wdata  output  64  current write beat.
- burst_rdata  input  64  current read beat.
- burst_resp  input  1  beat accepted (write) or beat valid (read).

Behaviour:
- Reset (synchronous): state=IDLE, beat counter=0. line_resp, burst_read and burst_write are 0. line_rdata, burst_address and burst_wdata are all zero.

State machine: IDLE, READ, WRITE, DONE.
- IDLE:
  - Request sampling happens only in IDLE.
  - If line_write=1, go to WRITE. Write has priority when both requests are high: writeback comes before fill.
  - Else if line_read=1, go to READ.
  - On entry to READ or WRITE: latch burst_address, clear the counter, and (write only) latch line_wdata into an internal 256-bit buffer.
  - Later changes on line_address or line_wdata have no effect until the next transaction.
- READ:
  - burst_read=1 continuously.
  - On each cycle with burst_resp=1: store burst_rdata into line_rdata beat[counter], then counter+1.
  - On the 4th burst_resp (counter==3), go to DONE. burst_read drops in the DONE cycle.
- WRITE:
  - burst_write=1 continuously.
  - burst_wdata = buffer beat[counter] (combinational from counter).
  - On each burst_resp: counter+1. On the 4th, go to DONE.
- DONE:
  - line_resp=1 for exactly this one cycle; burst_read and burst_write are 0.
  - Next state is IDLE unconditionally.
  - A request still high in the following IDLE cycle starts a new transaction. The cache must drop its request on line_resp.
- Latency:
  - Minimum 6 cycles from request sampled in IDLE to line_resp: 1 entry cycle, 4 beats, 1 DONE cycle.
  - burst_resp gaps stretch latency 1:1 and never lose or reorder beats.
- line_rdata:
  - Valid from the DONE cycle onward.
  - Holds until the next READ transaction overwrites its beats. A WRITE transaction does not disturb it.
- Counter: 2 bits, wraps 3→0 only on leaving READ/WRITE. burst_resp outside READ/WRITE is ignored.
- Reset mid-burst: returns to IDLE next edge. Requests drop immediately, no line_resp is issued, and the partial line_rdata is cleared to zero.
- Write beat 0 is driven from the first WRITE cycle. Downstream may respond in that same cycle.

Test Plan:
1. Read fill:
   - Stimulus: line_read=1, line_address=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with no gaps.
   - Response: burst_address=0x0000_1220; line_resp 6 cycles after request; line_rdata={0x44..44,0x33..33,0x22..22,0x11..11}.
2. Writeback:
   - Stimulus: line_write=1, line_wdata={D3,D2,D1,D0}, address 0xFFFF_FFE7.
   - Response: burst_address=0xFFFF_FFE0; burst_wdata shows D0, D1, D2, D3 on successive burst_resp; one line_resp pulse.
2. Simultaneous request and stretched beats:
   - Stimulus: line_read=line_write=1 in IDLE; burst_resp held 0 for 3 cycles between each beat.
   - Response: burst_write asserted, never burst_read; still exactly 4 beats; line_resp at cycle 1+4+9+1=15.
3. Back-to-back:
   - Stimulus: write then read.
   - Response: one IDLE cycle between the two; the read does not corrupt the write buffer; the write leaves the prior line_rdata unchanged.
5. Reset mid-read:
   - Stimulus: rst after 2 beats.
   - Response: next cycle IDLE with burst_read=0 and line_rdata=0; no line_resp; a fresh read then completes correctly.
6. Stray burst_resp:
   - Stimulus: burst_resp=1 while IDLE.
   - Response: no state change; counter stays 0.

Source files
------------

// File: rtl/cacheline_burst_responder_if.sv
// cacheline_burst_responder_if: cache line port and physical-memory burst bus
interface cacheline_burst_responder_if #(
  parameter int s_line = 256,
  parameter int s_beat = 64
);
  logic              line_read;
  logic              line_write;
  logic [31:0]       line_address;
  logic [s_line-1:0] line_wdata;
  logic [s_line-1:0] line_rdata;
  logic              line_resp;
  logic [31:0]       burst_address;
  logic              burst_read;
  logic              burst_write;
  logic [s_beat-1:0] burst_wdata;
  logic [s_beat-1:0] burst_rdata;
  logic              burst_resp;
  modport master (
    output line_read, line_write, line_address, line_wdata, burst_rdata, burst_resp,
    input  line_rdata, line_resp, burst_address, burst_read, burst_write, burst_wdata
  );
  modport slave (
    input  line_read, line_write, line_address, line_wdata, burst_rdata, burst_resp,
    output line_rdata, line_resp, burst_address, burst_read, burst_write, burst_wdata
  );
endinterface

// File: rtl/cacheline_burst_responder.sv
// cacheline_burst_responder: turns one 256-bit line read/write into a 4-beat 64-bit memory burst
module cacheline_burst_responder #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_beat   = 64
) (
  input logic clk,
  input logic rst,
  cacheline_burst_responder_if.slave bus
);
  localparam int n_beats = s_line / s_beat;
  typedef enum logic [1:0] {st_idle, st_read, st_write, st_done} state_t;
  state_t            state;
  logic [1:0]        cnt;
  logic [s_line-1:0] wbuf;
  assign bus.burst_wdata = wbuf[int'(cnt)*s_beat +: s_beat];
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= st_idle;
      cnt               <= '0;
      wbuf              <= '0;
      bus.line_rdata    <= '0;
      bus.line_resp     <= 1'b0;
      bus.burst_address <= '0;
      bus.burst_read    <= 1'b0;
      bus.burst_write   <= 1'b0;
    end else begin
      case (state)
        st_idle: if (bus.line_write || bus.line_read) begin
          state             <= bus.line_write ? st_write : st_read;
          bus.burst_write   <= bus.line_write;
          bus.burst_read    <= !bus.line_write;
          bus.burst_address <= {bus.line_address[31:s_offset], s_offset'(0)};
          cnt               <= '0;
          if (bus.line_write) wbuf <= bus.line_wdata;
        end
        st_read, st_write: if (bus.burst_resp) begin
          if (state == st_read) bus.line_rdata[int'(cnt)*s_beat +: s_beat] <= bus.burst_rdata;
          cnt <= cnt + 2'd1;
          if (cnt == 2'(n_beats - 1)) begin
            state           <= st_done;
            bus.burst_read  <= 1'b0;
            bus.burst_write <= 1'b0;
            bus.line_resp   <= 1'b1;
          end
        end
        default: begin
          state         <= st_idle;
          bus.line_resp <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_burst_responder.sv
// tb_cacheline_burst_responder: randomized line transactions checked against a queue-free line/beat model
module tb_cacheline_burst_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [255:0] exp_rdata = '0;
  cacheline_burst_responder_if bus();
  cacheline_burst_responder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction
  task automatic idle_check(input string tag);
    chk({tag, "_line_resp"}, bus.line_resp, 0);
    chk({tag, "_burst_read"}, bus.burst_read, 0);
    chk({tag, "_burst_write"}, bus.burst_write, 0);
  endtask
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rline,
                         input int g0_max, input int gmin, input int gmax, input int abort_after);
    bit is_wr = wr;
    int cyc = 1;
    int beats = 0;
    int gaps = 0;
    int gap;
    idle_check("pre");
    bus.line_read = rd;
    bus.line_write = wr;
    bus.line_address = addr;
    bus.line_wdata = wline;
    gap = $urandom_range(g0_max, 0);
    gaps += gap;
    @(negedge clk);
    cyc++;
    bus.line_address = $urandom;
    bus.line_wdata = rand256();
    chk("burst_address", bus.burst_address, {addr[31:5], 5'b0});
    while (!bus.line_resp && cyc < 300) begin
      chk("burst_read", bus.burst_read, !is_wr);
      chk("burst_write", bus.burst_write, is_wr);
      if (beats == abort_after) begin
        rst = 1'b1;
        bus.line_read = 1'b0;
        bus.line_write = 1'b0;
        bus.burst_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle_check("rst");
        chk("rst_line_rdata", bus.line_rdata, '0);
        chk("rst_burst_address", bus.burst_address, '0);
        exp_rdata = '0;
        return;
      end
      bus.burst_rdata = $urandom;
      if (gap > 0) begin
        gap--;
        bus.burst_resp = 1'b0;
      end else if (beats < 4) begin
        bus.burst_resp = 1'b1;
        bus.burst_rdata = rline[64*beats +: 64];
        if (is_wr) chk("burst_wdata", bus.burst_wdata, wline[64*beats +: 64]);
        beats++;
        if (beats < 4) begin
          gap = $urandom_range(gmax, gmin);
          gaps += gap;
        end
      end else bus.burst_resp = 1'b0;
      @(negedge clk);
      cyc++;
      bus.burst_resp = 1'b0;
    end
    chk("line_resp", bus.line_resp, 1);
    chk("latency", cyc, 6 + gaps);
    chk("beats", beats, 4);
    bus.line_read = 1'b0;
    bus.line_write = 1'b0;
    if (!is_wr) exp_rdata = rline;
    chk("line_rdata", bus.line_rdata, exp_rdata);
    chk("done_burst_read", bus.burst_read, 0);
    chk("done_burst_write", bus.burst_write, 0);
    @(negedge clk);
    chk("resp_pulse", bus.line_resp, 0);
  endtask
  initial begin
    bus.line_read = 1'b0;
    bus.line_write = 1'b0;
    bus.line_address = '0;
    bus.line_wdata = '0;
    bus.burst_rdata = '0;
    bus.burst_resp = 1'b0;
    repeat (2) @(negedge clk);
    idle_check("reset");
    chk("reset_line_rdata", bus.line_rdata, '0);
    chk("reset_burst_address", bus.burst_address, '0);
    chk("reset_burst_wdata", bus.burst_wdata, '0);
    rst = 1'b0;
    @(negedge clk);
    run_txn(1, 0, 32'h0000_1234, rand256(),
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0, 0, -1);
    chk("fill_line", bus.line_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    run_txn(0, 1, 32'hFFFF_FFE7, rand256(), rand256(), 0, 0, 0, -1);
    run_txn(1, 1, $urandom, rand256(), rand256(), 0, 3, 3, -1);
    run_txn(0, 1, $urandom, rand256(), rand256(), 0, 0, 0, -1);
    run_txn(1, 0, $urandom, rand256(), rand256(), 0, 0, 0, -1);
    run_txn(1, 0, $urandom, rand256(), rand256(), 0, 0, 1, 2);
    run_txn(1, 0, $urandom, rand256(), rand256(), 0, 0, 0, -1);
    bus.burst_resp = 1'b1;
    repeat (3) begin
      @(negedge clk);
      idle_check("stray");
    end
    bus.burst_resp = 1'b0;
    run_txn(1, 0, $urandom, rand256(), rand256(), 0, 0, 0, -1);
    for (int i = 0; i < 20; i++) begin
      int kind = $urandom_range(2, 0);
      run_txn(kind != 1, kind != 0, $urandom, rand256(), rand256(), 2, 0, 2, -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
